// File: rtl/dram_responder_model.sv
// dram_responder_model
//   On-chip stand-in for a DDR controller on the DRAM user-logic protocol.
//   Commands ({Address, Read}) enter an address FIFO. Write beats enter a
//   write buffer. A small FSM executes one 2-beat burst at a time against
//   block RAM. Read beats are returned through a first-word-fall-through
//   read buffer.
//
//   Ports
//     clk, rstn           clock, asynchronous active-low reset
//     Address, Read       command beat address (bit0 ignored) / 1 = read
//     WriteAF, AFfull     address FIFO push / full
//     WriteData, WriteWB  write beat / push into write buffer
//     WBfull              write buffer full
//     ReadData, ReadRB    read buffer head (0 while empty) / pop
//     RBempty, RBfull     read buffer flags
//     err                 sticky: push to a full FIFO or pop of an empty RB

// Count-tracked FIFO with a combinational head (first-word fall-through).
// The flags are registers loaded from the next count, so they follow a
// push or pop by one cycle. A push while full or a pop while empty is
// ignored here; the parent reports it.
module dram_resp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   cnt,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt_nxt;
    logic          push_ok, pop_ok;

    // A push into a full FIFO is dropped even if a pop frees a slot
    // in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rp];

    always_comb begin
        cnt_nxt = cnt;
        if (push_ok && !pop_ok)
            cnt_nxt = cnt + CW'(1);
        else if (!push_ok && pop_ok)
            cnt_nxt = cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push_ok) wp <= wp + AW'(1);
            if (pop_ok)  rp <= rp + AW'(1);
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == FULL_CNT);
            empty <= (cnt_nxt == '0);
        end
    end

    // Storage is not reset; the pointers alone define the contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= wdata;
    end
endmodule

module dram_responder_model #(
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 144,
    parameter int AF_DEPTH = 8,
    parameter int WB_DEPTH = 16,
    parameter int RB_DEPTH = 16,
    parameter int MEM_LOG2 = 10,
    parameter int READ_LAT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] Address,
    input  logic              Read,
    input  logic              WriteAF,
    output logic              AFfull,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              WriteWB,
    output logic              WBfull,
    output logic [DATA_W-1:0] ReadData,
    input  logic              ReadRB,
    output logic              RBempty,
    output logic              RBfull,
    output logic              err
);
    localparam int AF_W  = MEM_LOG2 + 1;          // {line, read}
    localparam int AF_CW = $clog2(AF_DEPTH+1);
    localparam int WB_CW = $clog2(WB_DEPTH+1);
    localparam int RB_CW = $clog2(RB_DEPTH+1);
    localparam int LW    = $clog2(READ_LAT+1);
    // The line index is Address[MEM_LOG2:1], so with the beat bit the
    // RAM is addressed by MEM_LOG2+1 bits.
    localparam int MA_W  = MEM_LOG2 + 1;

    localparam logic [RB_CW-1:0] RB_ROOM  = RB_CW'(RB_DEPTH-2);
    localparam logic [WB_CW-1:0] WB_BURST = WB_CW'(2);
    localparam logic [LW-1:0]    LAT_LAST = LW'(READ_LAT-2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR0  = 3'd1;
    localparam logic [2:0] S_WR1  = 3'd2;
    localparam logic [2:0] S_RDW  = 3'd3;
    localparam logic [2:0] S_RD0  = 3'd4;
    localparam logic [2:0] S_RD1  = 3'd5;

    logic [AF_W-1:0]     af_rdata;
    logic [AF_CW-1:0]    af_cnt;
    logic                af_empty, af_pop;
    logic [DATA_W-1:0]   wb_rdata;
    logic [WB_CW-1:0]    wb_cnt;
    logic                wb_empty, wb_pop;
    logic [DATA_W-1:0]   rb_rdata;
    logic [RB_CW-1:0]    rb_cnt;
    logic                rb_push;

    logic [2:0]          state, state_nxt;
    logic [MEM_LOG2-1:0] line;
    logic [LW-1:0]       lat_cnt;
    logic                mem_we, mem_re;
    logic [MA_W-1:0]     mem_addr;
    logic [DATA_W-1:0]   mem_q;
    logic [DATA_W-1:0]   mem [2**MA_W];
    logic                unused_sig;

    // High address bits alias; bit0 is meaningless for 2-beat bursts.
    assign unused_sig = ^{Address[ADDR_W-1:MEM_LOG2+1], Address[0], af_cnt, wb_empty};

    dram_resp_fifo #(.W(AF_W), .DEPTH(AF_DEPTH)) u_af (
        .clk(clk), .rstn(rstn), .push(WriteAF), .wdata({Address[MEM_LOG2:1], Read}),
        .pop(af_pop), .rdata(af_rdata), .cnt(af_cnt), .full(AFfull), .empty(af_empty)
    );

    dram_resp_fifo #(.W(DATA_W), .DEPTH(WB_DEPTH)) u_wb (
        .clk(clk), .rstn(rstn), .push(WriteWB), .wdata(WriteData),
        .pop(wb_pop), .rdata(wb_rdata), .cnt(wb_cnt), .full(WBfull), .empty(wb_empty)
    );

    dram_resp_fifo #(.W(DATA_W), .DEPTH(RB_DEPTH)) u_rb (
        .clk(clk), .rstn(rstn), .push(rb_push), .wdata(mem_q),
        .pop(ReadRB), .rdata(rb_rdata), .cnt(rb_cnt), .full(RBfull), .empty(RBempty)
    );

    assign ReadData = RBempty ? '0 : rb_rdata;

    always_comb begin
        state_nxt = state;
        af_pop    = 1'b0;
        wb_pop    = 1'b0;
        rb_push   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = {line, 1'b0};
        case (state)
            S_IDLE: begin
                // Reads reserve both RB slots up front, writes wait for
                // the whole burst in WB, so neither stalls mid-burst.
                if (!af_empty) begin
                    if (af_rdata[0] && rb_cnt <= RB_ROOM) begin
                        af_pop    = 1'b1;
                        state_nxt = S_RDW;
                    end else if (!af_rdata[0] && wb_cnt >= WB_BURST) begin
                        af_pop    = 1'b1;
                        state_nxt = S_WR0;
                    end
                end
            end
            S_WR0: begin
                wb_pop    = 1'b1;
                mem_we    = 1'b1;
                state_nxt = S_WR1;
            end
            S_WR1: begin
                wb_pop    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line, 1'b1};
                state_nxt = S_IDLE;
            end
            S_RDW: begin
                // lat_cnt runs 0..READ_LAT-2; the last step launches the
                // beat0 RAM read so its data is in mem_q during RD0.
                if (lat_cnt == LAT_LAST) begin
                    mem_re    = 1'b1;
                    state_nxt = S_RD0;
                end
            end
            S_RD0: begin
                rb_push   = 1'b1;
                mem_re    = 1'b1;
                mem_addr  = {line, 1'b1};
                state_nxt = S_RD1;
            end
            S_RD1: begin
                rb_push   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            line    <= '0;
            lat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (af_pop) line <= af_rdata[AF_W-1:1];
            if (state == S_RDW) lat_cnt <= lat_cnt + LW'(1);
            else                lat_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err <= 1'b0;
        else if ((WriteAF && AFfull) || (WriteWB && WBfull) || (ReadRB && RBempty))
            err <= 1'b1;
    end

    // Block RAM: one access per cycle, synchronous read.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= wb_rdata;
        if (mem_re) mem_q <= mem[mem_addr];
    end
endmodule
